wb_stage: RTL and testbench

- Writeback stage of the vector encryption pipeline. Sits directly downstream of the memory stage and its MEM/WB pipe register.
- Selects either the memory read data or the ALU result, then commits it to the integer or vector register file.
- Issues the registered jump redirect to fetch, tracks retired instructions, and holds the core halted after an end instruction.
- Owns both register files and serves the decode read ports.

---
 rtl/wb_stage.sv | 128 ++++++++++++
 tb/tb_wb_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: picks memory or ALU data, commits it to the integer/vector
// register files, issues the registered jump redirect and halts on an end
// instruction. Optional macro WB_BYPASS_EN enables write-first read bypass.
module wb_stage #(
    parameter int REGI_BITS = 4,
    parameter int VECT_BITS = 2,
    parameter int REGI_SIZE = 16,
    parameter int VECT_SIZE = 8,
    parameter int ELEM_SIZE = 8,
    parameter int CNT_BITS  = 16,
    localparam int W        = ELEM_SIZE * VECT_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enableReg_i,
    input  logic                 enableJump_i,
    input  logic                 flagMemRead_i,
    input  logic                 flagEnd_i,
    input  logic                 flagNop_i,
    input  logic                 writeResultInt_i,
    input  logic                 writeResultV_i,
    input  logic [9:0]           jumpAddress_i,
    input  logic [REGI_BITS-1:0] intRegDest_i,
    input  logic [VECT_BITS-1:0] vecRegDest_i,
    input  logic [W-1:0]         mem_rd_i,
    input  logic [W-1:0]         alu_res_i,
    input  logic [REGI_BITS-1:0] int_ra1_i,
    input  logic [REGI_BITS-1:0] int_ra2_i,
    input  logic [VECT_BITS-1:0] vec_ra1_i,
    input  logic [VECT_BITS-1:0] vec_ra2_i,
    output logic [REGI_SIZE-1:0] int_rd1_o,
    output logic [REGI_SIZE-1:0] int_rd2_o,
    output logic [W-1:0]         vec_rd1_o,
    output logic [W-1:0]         vec_rd2_o,
    output logic                 pc_load_o,
    output logic [9:0]           pc_target_o,
    output logic                 halted_o,
    output logic [CNT_BITS-1:0]  retired_cnt_o
);

    localparam int NI = 1 << REGI_BITS;
    localparam int NV = 1 << VECT_BITS;

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t state, state_nxt;

    logic                 valid;
    logic                 int_we;
    logic                 vec_we;
    logic                 jump_go;
    logic [W-1:0]         wb_data;
    logic [REGI_SIZE-1:0] int_rf [NI];
    logic [W-1:0]         vec_rf [NV];

    assign valid   = !flagNop_i && (state == RUN);
    assign wb_data = flagMemRead_i ? mem_rd_i : alu_res_i;
    assign int_we  = valid && enableReg_i && writeResultInt_i;
    assign vec_we  = valid && enableReg_i && writeResultV_i;
    // End takes priority over a jump carried by the same instruction.
    assign jump_go = valid && enableJump_i && !flagEnd_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (valid && flagEnd_i) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    assign halted_o = (state == HALT);

    // Entry 0 is reset and never written, so it stays zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NI; i++) int_rf[i] <= '0;
        end else if (int_we && (intRegDest_i != '0)) begin
            int_rf[intRegDest_i] <= wb_data[REGI_SIZE-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NV; i++) vec_rf[i] <= '0;
        end else if (vec_we) begin
            vec_rf[vecRegDest_i] <= wb_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_load_o   <= 1'b0;
            pc_target_o <= '0;
        end else begin
            pc_load_o <= jump_go;
            if (jump_go) pc_target_o <= jumpAddress_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            retired_cnt_o <= '0;
        else if (valid && (retired_cnt_o != {CNT_BITS{1'b1}}))
            retired_cnt_o <= retired_cnt_o + 1'b1;
    end

    always_comb begin
        int_rd1_o = (int_ra1_i == '0) ? '0 : int_rf[int_ra1_i];
        int_rd2_o = (int_ra2_i == '0) ? '0 : int_rf[int_ra2_i];
        vec_rd1_o = vec_rf[vec_ra1_i];
        vec_rd2_o = vec_rf[vec_ra2_i];
`ifdef WB_BYPASS_EN
        if (int_we && (int_ra1_i == intRegDest_i) && (int_ra1_i != '0))
            int_rd1_o = wb_data[REGI_SIZE-1:0];
        if (int_we && (int_ra2_i == intRegDest_i) && (int_ra2_i != '0))
            int_rd2_o = wb_data[REGI_SIZE-1:0];
        if (vec_we && (vec_ra1_i == vecRegDest_i)) vec_rd1_o = wb_data;
        if (vec_we && (vec_ra2_i == vecRegDest_i)) vec_rd2_o = wb_data;
`endif
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed plus randomized bench for wb_stage against a behavioural model of
// the register files, jump redirect, retire counter and halt behaviour.
module tb_wb_stage;

    localparam int CNT_BITS = 4;
    localparam int CMAX     = (1 << CNT_BITS) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_reg, en_jump, mem_read, f_end, f_nop, w_int, w_vec;
    logic [9:0]  jaddr;
    logic [3:0]  idest, ra1, ra2;
    logic [1:0]  vdest, va1, va2;
    logic [63:0] mem_rd, alu_res;
    logic [15:0] rd1, rd2;
    logic [63:0] vrd1, vrd2;
    logic        pc_load, halted;
    logic [9:0]  pc_target;
    logic [CNT_BITS-1:0] cnt;

    wb_stage #(.CNT_BITS(CNT_BITS)) dut (
        .clk_i(clk), .rst_i(rst),
        .enableReg_i(en_reg), .enableJump_i(en_jump), .flagMemRead_i(mem_read),
        .flagEnd_i(f_end), .flagNop_i(f_nop),
        .writeResultInt_i(w_int), .writeResultV_i(w_vec),
        .jumpAddress_i(jaddr), .intRegDest_i(idest), .vecRegDest_i(vdest),
        .mem_rd_i(mem_rd), .alu_res_i(alu_res),
        .int_ra1_i(ra1), .int_ra2_i(ra2), .vec_ra1_i(va1), .vec_ra2_i(va2),
        .int_rd1_o(rd1), .int_rd2_o(rd2), .vec_rd1_o(vrd1), .vec_rd2_o(vrd2),
        .pc_load_o(pc_load), .pc_target_o(pc_target), .halted_o(halted),
        .retired_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    // reference model
    logic [15:0] mi [16];
    logic [63:0] mv [4];
    bit          m_halt, m_pcl;
    logic [9:0]  m_pct;
    int          m_cnt;
    int          vecs = 0, errs = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mi[i] = '0;
        for (int i = 0; i < 4; i++) mv[i] = '0;
        m_halt = 0; m_pcl = 0; m_pct = '0; m_cnt = 0;
    endtask

    function automatic bit m_valid();
        return !f_nop && !m_halt;
    endfunction

    function automatic logic [63:0] m_wb();
        return mem_read ? mem_rd : alu_res;
    endfunction

    function automatic logic [15:0] exp_int(input logic [3:0] a);
        logic [15:0] r;
        r = (a == 0) ? 16'h0 : mi[a];
`ifdef WB_BYPASS_EN
        if (m_valid() && en_reg && w_int && a == idest && a != 0) r = m_wb()[15:0];
`endif
        return r;
    endfunction

    function automatic logic [63:0] exp_vec(input logic [1:0] a);
        logic [63:0] r;
        r = mv[a];
`ifdef WB_BYPASS_EN
        if (m_valid() && en_reg && w_vec && a == vdest) r = m_wb();
`endif
        return r;
    endfunction

    task automatic idle();
        en_reg = 0; en_jump = 0; mem_read = 0; f_end = 0; f_nop = 0;
        w_int = 0; w_vec = 0; jaddr = '0; idest = '0; vdest = '0;
        mem_rd = '0; alu_res = '0;
    endtask

    // Compare combinational read ports in the middle of the cycle.
    task automatic pre_edge();
        @(negedge clk);
        chk("int_rd1", 64'(rd1), 64'(exp_int(ra1)));
        chk("int_rd2", 64'(rd2), 64'(exp_int(ra2)));
        chk("vec_rd1", vrd1, exp_vec(va1));
        chk("vec_rd2", vrd2, exp_vec(va2));
    endtask

    // Advance the model across the edge, then compare registered outputs.
    task automatic post_edge();
        bit v;
        logic [63:0] wb;
        @(posedge clk);
        #1;
        v  = m_valid();
        wb = m_wb();
        m_pcl = v && en_jump && !f_end;
        if (m_pcl) m_pct = jaddr;
        if (v && en_reg && w_int && idest != 0) mi[idest] = wb[15:0];
        if (v && en_reg && w_vec) mv[vdest] = wb;
        if (v && m_cnt < CMAX) m_cnt++;
        if (v && f_end) m_halt = 1;
        chk("pc_load", 64'(pc_load), 64'(m_pcl));
        chk("pc_target", 64'(pc_target), 64'(m_pct));
        chk("halted", 64'(halted), 64'(m_halt));
        chk("retired_cnt", 64'(cnt), 64'(m_cnt));
    endtask

    task automatic step();
        pre_edge();
        post_edge();
    endtask

    // Asynchronous reset pulse away from the clock edge.
    task automatic pulse_reset();
        #1 rst = 1;
        #1;
        model_reset();
        chk("rst_pc_load", 64'(pc_load), 64'(0));
        chk("rst_halted", 64'(halted), 64'(0));
        chk("rst_cnt", 64'(cnt), 64'(0));
        chk("rst_pc_target", 64'(pc_target), 64'(0));
        @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        idle();
        ra1 = 0; ra2 = 0; va1 = 0; va2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc_load", 64'(pc_load), 64'(0));
        chk("reset_target", 64'(pc_target), 64'(0));
        chk("reset_halted", 64'(halted), 64'(0));
        chk("reset_cnt", 64'(cnt), 64'(0));
        ra1 = 3; va1 = 2;
        #1 chk("reset_r3", 64'(rd1), 64'(0));
        rst = 0;

        // integer write from ALU
        en_reg = 1; w_int = 1; idest = 3; alu_res = 64'h0000_0000_0000_BEEF;
        step();
        idle();
        #1 chk("r3_beef", 64'(rd1), 64'h BEEF);
        chk("cnt_one", 64'(cnt), 64'd1);

        // memory-sourced vector write
        en_reg = 1; w_vec = 1; vdest = 2; mem_read = 1; mem_rd = 64'h0102030405060708;
        alu_res = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        idle();
        #1 chk("v2_mem", vrd1, 64'h0102030405060708);

        // R0 stays zero
        en_reg = 1; w_int = 1; idest = 0; alu_res = 64'h1234; ra1 = 0;
        step();
        idle();
        #1 chk("r0_zero", 64'(rd1), 64'h0);

        // same-cycle read of a register being written
        en_reg = 1; w_int = 1; idest = 5; alu_res = 64'hAAAA; ra1 = 5;
        pre_edge();
`ifdef WB_BYPASS_EN
        chk("r5_same", 64'(rd1), 64'h AAAA);
`else
        chk("r5_same", 64'(rd1), 64'h0);
`endif
        post_edge();
        idle();
        #1 chk("r5_next", 64'(rd1), 64'h AAAA);

        // jump pulse, then a bubble carrying the same jump
        en_jump = 1; jaddr = 10'h2A5;
        step();
        chk("jump_pulse", 64'(pc_load), 64'd1);
        chk("jump_target", 64'(pc_target), 64'h2A5);
        idle();
        step();
        chk("jump_single", 64'(pc_load), 64'd0);
        en_jump = 1; jaddr = 10'h11B; f_nop = 1; en_reg = 1; w_int = 1; idest = 6;
        alu_res = 64'h5555;
        step();
        chk("nop_no_pulse", 64'(pc_load), 64'd0);
        chk("nop_target", 64'(pc_target), 64'h2A5);

        // end with write and jump
        idle();
        en_reg = 1; w_int = 1; idest = 7; alu_res = 64'h0011; f_end = 1; en_jump = 1;
        jaddr = 10'h3FF; ra1 = 7;
        step();
        chk("end_no_pulse", 64'(pc_load), 64'd0);
        chk("end_halted", 64'(halted), 64'd1);
        idle();
        #1 chk("r7_end", 64'(rd1), 64'h0011);
        en_reg = 1; w_int = 1; idest = 7; alu_res = 64'h9999; en_jump = 1; jaddr = 10'h055;
        step();
        step();
        chk("halt_hold_r7", 64'(rd1), 64'h0011);
        idle();
        pulse_reset();
        #1 chk("after_rst_r7", 64'(rd1), 64'h0);

        // counter saturation
        for (int i = 0; i < 20; i++) step();
        chk("cnt_sat", 64'(cnt), 64'(CMAX));
        pulse_reset();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            en_reg   = $urandom_range(0, 3) != 0;
            en_jump  = $urandom_range(0, 3) == 0;
            mem_read = $urandom_range(0, 1);
            f_end    = $urandom_range(0, 39) == 0;
            f_nop    = $urandom_range(0, 4) == 0;
            w_int    = $urandom_range(0, 1);
            w_vec    = $urandom_range(0, 1);
            jaddr    = 10'($urandom);
            idest    = 4'($urandom); vdest = 2'($urandom);
            ra1      = 4'($urandom); ra2   = 4'($urandom);
            va1      = 2'($urandom); va2   = 2'($urandom);
            mem_rd   = {$urandom, $urandom};
            alu_res  = {$urandom, $urandom};
            step();
            if (m_halt && $urandom_range(0, 5) == 0) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
